sqrt_core: RTL

- Arithmetic stage of the fp16 square-root pipeline. Sits between normalize (upstream) and pack (downstream).
- Takes an unpacked, normalized operand (sign, signed unbiased exponent, 11-bit mantissa with hidden one) plus class flags.
- Computes the square root with a one-bit-per-cycle restoring algorithm and rounds to nearest even.
- Emits an unpacked result and class flags for pack to re-encode.

---
 rtl/sqrt2_pkg.sv | 21 ++
 rtl/sqrt_core_if.sv | 36 +++
 rtl/sqrt_step.sv | 21 ++
 rtl/sqrt_core.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sqrt2_pkg.sv
// Shared types and constants for the fp16 square-root pipeline stages.
package sqrt2_pkg;
  localparam int MANT_W = 11;
  localparam int EXP_W  = 7;
  localparam int ITERS  = 12;
  localparam int RAD_W  = 24;
  localparam int REM_W  = 14;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROUND} state_e;

  // Unpacked operand/result as exchanged between normalize, sqrt and pack.
  typedef struct packed {
    logic                     sign;
    logic signed [EXP_W-1:0]  exp;
    logic [MANT_W-1:0]        mant;
    logic                     is_num;
    logic                     is_nan;
    logic                     is_pinf;
    logic                     is_ninf;
  } fp_unpacked_t;
endpackage

// File: rtl/sqrt_core_if.sv
// Operand/result bundle of the sqrt stage.
// Handshake: an operand transfers on a rising edge where in_valid, in_ready and
// enable are all 1; out_valid is a single enabled-cycle pulse with no back-pressure.
interface sqrt_core_if;
  import sqrt2_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_is_num;
  logic                    in_is_nan;
  logic                    in_is_pinf;
  logic                    in_is_ninf;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [MANT_W-1:0]       in_mant;
  logic                    out_valid;
  logic                    out_is_num;
  logic                    out_is_nan;
  logic                    out_is_pinf;
  logic                    out_is_ninf;
  logic                    out_sign;
  logic signed [EXP_W-1:0] out_exp;
  logic [MANT_W-1:0]       out_mant;

  modport slave (
    input  in_valid, in_is_num, in_is_nan, in_is_pinf, in_is_ninf, in_sign, in_exp, in_mant,
    output in_ready, out_valid, out_is_num, out_is_nan, out_is_pinf, out_is_ninf,
           out_sign, out_exp, out_mant
  );

  modport master (
    output in_valid, in_is_num, in_is_nan, in_is_pinf, in_is_ninf, in_sign, in_exp, in_mant,
    input  in_ready, out_valid, out_is_num, out_is_nan, out_is_pinf, out_is_ninf,
           out_sign, out_exp, out_mant
  );
endinterface

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: consumes two radicand bits, yields one root bit.
module sqrt_step
  import sqrt2_pkg::*;
(
  input  logic [REM_W-1:0] rem_i,
  input  logic [ITERS-1:0] root_i,
  input  logic [1:0]       rad2_i,
  output logic [REM_W-1:0] rem_o,
  output logic             bit_o
);
  logic [REM_W+1:0] lhs;
  logic [REM_W-1:0] rhs;
  logic [REM_W-1:0] diff;

  assign lhs = {rem_i, rad2_i};
  assign rhs = {root_i, 2'b01};
  // When the trial is negative lhs < rhs, so the low REM_W bits hold the restored value.
  assign bit_o = (lhs >= {2'b00, rhs});
  assign diff  = lhs[REM_W-1:0] - rhs;
  assign rem_o = bit_o ? diff : lhs[REM_W-1:0];
endmodule

// File: rtl/sqrt_core.sv
// fp16 square-root arithmetic stage: restoring root, one bit per enabled cycle,
// round-to-nearest-even, class override; fixed 14-cycle latency.
module sqrt_core
  import sqrt2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  sqrt_core_if.slave bus,
  output state_e     dbg_state_o
);
  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [RAD_W-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [ITERS-1:0]   root_q, root_d;
  fp_unpacked_t       op_q, op_d;
  fp_unpacked_t       out_q, out_d;
  logic               out_valid_q, out_valid_d;

  logic [REM_W-1:0]   step_rem;
  logic               step_bit;
  logic [ITERS-1:0]   m2;
  logic [MANT_W-1:0]  rnd_mant;
  logic               rnd_inc;
  logic [MANT_W:0]    rnd_sum;
  logic               rnd_carry;
  logic signed [EXP_W-1:0] half_exp;
  fp_unpacked_t       res;

  sqrt_step u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .rad2_i (rad_q[RAD_W-1 -: 2]),
    .rem_o  (step_rem),
    .bit_o  (step_bit)
  );

  // Odd exponents borrow one into the mantissa so the halved exponent is exact.
  assign m2 = bus.in_exp[0] ? {bus.in_mant, 1'b0} : {1'b0, bus.in_mant};

  assign rnd_mant  = root_q[ITERS-1:1];
  assign rnd_inc   = root_q[0] & ((|rem_q) | rnd_mant[0]);
  assign rnd_sum   = {1'b0, rnd_mant} + {{MANT_W{1'b0}}, rnd_inc};
  assign rnd_carry = rnd_sum[MANT_W];
  assign half_exp  = $signed(op_q.exp) >>> 1;

  always_comb begin
    res = '0;
    if (op_q.is_nan || op_q.is_ninf) begin
      res.is_nan = 1'b1;
    end else if (op_q.is_pinf) begin
      res.is_pinf = 1'b1;
    end else if (op_q.is_num && op_q.mant == '0) begin
      res.is_num = 1'b1;
      res.sign   = op_q.sign;
    end else if (op_q.is_num && !op_q.sign) begin
      res.is_num = 1'b1;
      res.mant   = rnd_carry ? {1'b1, {(MANT_W-1){1'b0}}} : rnd_sum[MANT_W-1:0];
      res.exp    = half_exp + {{(EXP_W-1){1'b0}}, rnd_carry};
    end else begin
      res.is_nan = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    op_d        = op_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (enable) begin
      out_valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_d.sign    = bus.in_sign;
            op_d.exp     = {bus.in_exp[EXP_W-1:1], 1'b0};
            op_d.mant    = bus.in_mant;
            op_d.is_num  = bus.in_is_num;
            op_d.is_nan  = bus.in_is_nan;
            op_d.is_pinf = bus.in_is_pinf;
            op_d.is_ninf = bus.in_is_ninf;
            rad_d        = {m2, {(RAD_W-ITERS){1'b0}}};
            rem_d        = '0;
            root_d       = '0;
            cnt_d        = '0;
            state_d      = S_CALC;
          end
        end
        S_CALC: begin
          rad_d  = {rad_q[RAD_W-3:0], 2'b00};
          rem_d  = step_rem;
          root_d = {root_q[ITERS-2:0], step_bit};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'(ITERS-1)) state_d = S_ROUND;
        end
        S_ROUND: begin
          out_d       = res;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      op_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      op_q        <= op_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_is_num  = out_q.is_num;
  assign bus.out_is_nan  = out_q.is_nan;
  assign bus.out_is_pinf = out_q.is_pinf;
  assign bus.out_is_ninf = out_q.is_ninf;
  assign bus.out_sign    = out_q.sign;
  assign bus.out_exp     = out_q.exp;
  assign bus.out_mant    = out_q.mant;
  assign dbg_state_o     = state_q;
endmodule
